ahb_master: RTL and testbench
=============================

AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 SHALL have port HCLK  in  1  clock; all flops rise on posedge HCLK.
REQ-002 SHALL have port HRESETn  in  1  reset, asynchronous, active-low; clock HCLK.
REQ-003 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake; accepted on a rising edge where both are 1.
REQ-004 SHALL have ports cmd_write in 1 (1=write), cmd_burst in 1 (0=SINGLE, 1=INCR4), cmd_addr in 32 (start byte address).
REQ-005 SHALL have port cmd_wdata  in  128  write data; beat n uses bits [32n+31:32n].
REQ-006 SHALL have AHB outputs HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HWDATA 32.
REQ-007 SHALL have AHB inputs HREADY 1, HRESP 2, HRDATA 32.
REQ-008 SHALL have outputs rd_data 32, rd_valid 1, done 1, err 1, busy 1.

Function
REQ-009 SHALL support HTRANS encodings IDLE=00, NONSEQ=10, SEQ=11; BUSY=01 SHALL never be driven.
REQ-010 SHALL drive HSIZE=3'b010 (word) always; HBURST=000 for SINGLE, 011 for INCR4, 000 when HTRANS=IDLE.
REQ-011 SHALL hold cmd_ready=1 only in state IDLE; busy = ~cmd_ready.
REQ-012 SHALL implement states IDLE, ADDR (address phase, no data phase pending), PIPE (address phase of beat n+1 overlapped with data phase of beat n), LAST (data phase of final beat only), ERR (second error cycle).
REQ-013 Transitions: IDLE->ADDR on accept; ADDR->PIPE (INCR4) or LAST (SINGLE) on HREADY=1; PIPE->PIPE until beat 3 address taken, then ->LAST; LAST->IDLE on HREADY=1 with HRESP=OKAY.
REQ-014 On accept at edge T, HTRANS=NONSEQ, HADDR=cmd_addr, HWRITE=cmd_write SHALL be driven from cycle T+1.
REQ-015 INCR4 beats 1..3 SHALL use HTRANS=SEQ and HADDR = previous HADDR + 4 (32-bit wrap not permitted, see REQ-019).
REQ-016 HWDATA SHALL present beat n data throughout beat n's data phase (cycle after its address phase completes); 0 on reads.
REQ-017 While HREADY=0, HADDR, HTRANS, HWRITE, HBURST, HWDATA SHALL hold their values; no counter advances.
REQ-018 Reads: at each edge ending a data phase with HREADY=1, HRESP=OKAY, rd_data<=HRDATA and rd_valid SHALL pulse 1 cycle.
REQ-019 Command with cmd_addr[1:0]!=0, or INCR4 with cmd_addr[9:0]>10'h3F0 (1 KB crossing), SHALL be accepted, generate no bus transfer, and pulse err and done 1 cycle after acceptance.
REQ-020 Zero-wait latency: SINGLE done pulse in cycle T+3; INCR4 rd_valid at T+3..T+6, done at T+6.
REQ-021 HRESP=ERROR with HREADY=0 (first error cycle) SHALL cause HTRANS=IDLE in the next cycle (pending SEQ cancelled), state ->ERR.
REQ-022 In ERR, on HREADY=1 with HRESP=ERROR: no rd_valid for that beat, err and done SHALL pulse together, state ->IDLE; remaining beats abandoned.
REQ-023 done SHALL pulse exactly once per accepted command; err only with done.
REQ-024 HRESP RETRY/SPLIT (10/11) SHALL be treated as ERROR.
REQ-025 cmd_valid while busy SHALL be ignored; new command acceptable in the cycle done is high (back-to-back: next NONSEQ one cycle after done).

Reset
REQ-026 HRESETn=0 SHALL immediately force: state IDLE, HTRANS=00, HADDR=0, HWRITE=0, HBURST=000, HSIZE=010, HWDATA=0, rd_data=0, rd_valid=0, done=0, err=0, busy=0, cmd_ready=1.
REQ-027 Reset asserted mid-burst SHALL abandon the transfer with no done/err pulse; first command after release starts from NONSEQ.

Verification
REQ-028 SINGLE write 0x8000_0010, data 0xDEAD_BEEF, zero-wait slave -> NONSEQ/HADDR=0x8000_0010 at T+1, HWDATA=0xDEAD_BEEF at T+2, done at T+3.
REQ-029 INCR4 read 0x8400_0000, HRDATA 1,2,3,4 -> HADDR 0x..00/04/08/0C NONSEQ,SEQ,SEQ,SEQ; rd_valid T+3..T+6 with data 1..4; done T+6.
REQ-030 INCR4 write, slave inserts 2 wait states on beat 1 -> all AHB outputs stable during waits; done delayed to T+8.
REQ-031 INCR4 read, ERROR on beat 2 -> HTRANS=IDLE next cycle, rd_valid only for beats 0,1, err+done together, no beat-3 address.
REQ-032 cmd_addr=0x8000_0002 and INCR4 at 0x8000_03F4 -> no NONSEQ, err+done 1 cycle after accept.
REQ-033 HRESETn low during beat 2 of INCR4 -> outputs to reset values immediately, no done; subsequent SINGLE completes normally.

Source files
------------

// File: rtl/ahb_master_if.sv
// Command-side and AHB-side signal bundle for the ahb_master block.
// The master modport is the DUT view; the slave modport is the bus/peer view.
interface ahb_master_if;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_write;
   logic         cmd_burst;
   logic [31:0]  cmd_addr;
   logic [127:0] cmd_wdata;
   logic [31:0]  HADDR;
   logic [1:0]   HTRANS;
   logic         HWRITE;
   logic [2:0]   HSIZE;
   logic [2:0]   HBURST;
   logic [31:0]  HWDATA;
   logic         HREADY;
   logic [1:0]   HRESP;
   logic [31:0]  HRDATA;
   logic [31:0]  rd_data;
   logic         rd_valid;
   logic         done;
   logic         err;
   logic         busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_burst, cmd_addr, cmd_wdata,
      input  HREADY, HRESP, HRDATA,
      output cmd_ready, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
      output rd_data, rd_valid, done, err, busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_burst, cmd_addr, cmd_wdata,
      output HREADY, HRESP, HRDATA,
      input  cmd_ready, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
      input  rd_data, rd_valid, done, err, busy
   );
endinterface

// File: rtl/ahb_master.sv
// AHB-Lite master issuing one SINGLE or INCR4 word transfer per accepted command,
// with pipelined address/data phases and two-cycle error response handling.
module ahb_master (
   input  logic         HCLK,
   input  logic         HRESETn,
   ahb_master_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST, S_ERR} state_t;

   localparam logic [1:0] TR_IDLE      = 2'b00;
   localparam logic [1:0] TR_NONSEQ    = 2'b10;
   localparam logic [1:0] TR_SEQ       = 2'b11;
   localparam logic [2:0] BURST_SINGLE = 3'b000;
   localparam logic [2:0] BURST_INCR4  = 3'b011;

   state_t       state_q, state_d;
   logic [1:0]   beat_q, beat_d;
   logic         burst_q, burst_d;
   logic [127:0] wdata_q, wdata_d;
   logic [31:0]  haddr_q, haddr_d;
   logic [1:0]   htrans_q, htrans_d;
   logic         hwrite_q, hwrite_d;
   logic [2:0]   hburst_q, hburst_d;
   logic [31:0]  hwdata_q, hwdata_d;
   logic [31:0]  rd_data_q, rd_data_d;
   logic         rd_valid_q, rd_valid_d;
   logic         done_q, done_d;
   logic         err_q, err_d;

   logic         bad_cmd;
   logic         resp_err;
   logic [31:0]  next_word;

   function automatic logic [31:0] beat_word(input logic [127:0] d, input logic [1:0] n);
      return d[{n, 5'b00000} +: 32];
   endfunction

   // Misaligned starts and INCR4 bursts that would cross a 1 KB boundary are refused on the bus.
   assign bad_cmd   = (bus.cmd_addr[1:0] != 2'b00) ||
                      (bus.cmd_burst && (bus.cmd_addr[9:0] > 10'h3F0));
   assign resp_err  = (bus.HRESP != 2'b00);
   assign next_word = hwrite_q ? beat_word(wdata_q, beat_q) : 32'h0;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      burst_d    = burst_q;
      wdata_d    = wdata_q;
      haddr_d    = haddr_q;
      htrans_d   = htrans_q;
      hwrite_d   = hwrite_q;
      hburst_d   = hburst_q;
      hwdata_d   = hwdata_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (bad_cmd) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  state_d  = S_ADDR;
                  haddr_d  = bus.cmd_addr;
                  htrans_d = TR_NONSEQ;
                  hwrite_d = bus.cmd_write;
                  hburst_d = bus.cmd_burst ? BURST_INCR4 : BURST_SINGLE;
                  burst_d  = bus.cmd_burst;
                  wdata_d  = bus.cmd_wdata;
                  beat_d   = 2'd0;
               end
            end
         end
         S_ADDR: begin
            if (bus.HREADY) begin
               hwdata_d = next_word;
               if (burst_q) begin
                  state_d  = S_PIPE;
                  beat_d   = beat_q + 2'd1;
                  haddr_d  = haddr_q + 32'd4;
                  htrans_d = TR_SEQ;
               end else begin
                  state_d  = S_LAST;
                  htrans_d = TR_IDLE;
                  hburst_d = BURST_SINGLE;
               end
            end
         end
         S_PIPE, S_LAST: begin
            // A data-phase error cancels any address still queued behind it.
            if (resp_err) begin
               htrans_d = TR_IDLE;
               hburst_d = BURST_SINGLE;
               if (bus.HREADY) begin
                  state_d  = S_IDLE;
                  done_d   = 1'b1;
                  err_d    = 1'b1;
                  hwdata_d = 32'h0;
               end else begin
                  state_d = S_ERR;
               end
            end else if (bus.HREADY) begin
               if (!hwrite_q) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = bus.HRDATA;
               end
               if (state_q == S_LAST) begin
                  state_d  = S_IDLE;
                  done_d   = 1'b1;
                  hwdata_d = 32'h0;
               end else begin
                  hwdata_d = next_word;
                  if (beat_q == 2'd3) begin
                     state_d  = S_LAST;
                     htrans_d = TR_IDLE;
                     hburst_d = BURST_SINGLE;
                  end else begin
                     beat_d   = beat_q + 2'd1;
                     haddr_d  = haddr_q + 32'd4;
                     htrans_d = TR_SEQ;
                  end
               end
            end
         end
         S_ERR: begin
            if (bus.HREADY) begin
               state_d  = S_IDLE;
               done_d   = 1'b1;
               err_d    = 1'b1;
               hwdata_d = 32'h0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         beat_q     <= 2'd0;
         burst_q    <= 1'b0;
         haddr_q    <= 32'h0;
         htrans_q   <= TR_IDLE;
         hwrite_q   <= 1'b0;
         hburst_q   <= BURST_SINGLE;
         hwdata_q   <= 32'h0;
         rd_data_q  <= 32'h0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         burst_q    <= burst_d;
         haddr_q    <= haddr_d;
         htrans_q   <= htrans_d;
         hwrite_q   <= hwrite_d;
         hburst_q   <= hburst_d;
         hwdata_q   <= hwdata_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Command write data is only a payload buffer; it is always loaded before use.
   always_ff @(posedge HCLK) begin
      wdata_q <= wdata_d;
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.HADDR     = haddr_q;
   assign bus.HTRANS    = htrans_q;
   assign bus.HWRITE    = hwrite_q;
   assign bus.HSIZE     = 3'b010;
   assign bus.HBURST    = hburst_q;
   assign bus.HWDATA    = hwdata_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: a configurable AHB slave, a vector table of commands with
// expected latency/error, and queues of expected bus transfers and read data.
module tb_ahb_master;
   logic HCLK;
   logic HRESETn;
   ahb_master_if bus();

   ahb_master dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic         wr;
      logic         burst;
      logic [31:0]  addr;
      logic [127:0] wdata;
      logic [31:0]  rbase;
      int           wait_beat;
      int           wait_n;
      int           err_beat;
      logic [1:0]   err_code;
      bit           hold;
      int           exp_lat;
      bit           exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] a;
      logic [1:0]  t;
      logic        w;
      logic [2:0]  b;
      logic [2:0]  s;
   } xfer_t;

   xfer_t       exp_a[$];
   logic [31:0] exp_wd[$];
   logic [31:0] exp_rd[$];
   vec_t        tbl[12];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_cnt = 0;
   int n_cmds = 0;

   // slave configuration for the command in flight
   int          wait_beat = -1;
   int          wait_n = 0;
   int          err_beat = -1;
   logic [1:0]  err_code = 2'b01;
   logic [31:0] cur_addr = 32'h0;
   logic [31:0] rd_base = 32'h0;

   logic        s_dp;
   int          s_beat;
   int          s_wcnt;
   logic        s_errph;

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [109:0] out_vec();
      return {bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HBURST, bus.HSIZE, bus.HWDATA,
              bus.rd_data, bus.rd_valid, bus.done, bus.err, bus.busy, bus.cmd_ready};
   endfunction

   localparam logic [109:0] RESET_VEC = {2'b00, 32'h0, 1'b0, 3'b000, 3'b010, 32'h0,
                                         32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   always @(posedge HCLK) cyc <= cyc + 1;

   // Slave: zero-wait unless configured; two-cycle error response on err_beat.
   always_comb begin
      bus.HREADY = 1'b1;
      bus.HRESP  = 2'b00;
      bus.HRDATA = 32'h0;
      if (s_dp) begin
         bus.HRDATA = rd_base + 32'(s_beat);
         if (s_beat == err_beat) begin
            bus.HRESP  = err_code;
            bus.HREADY = s_errph;
         end else if (s_beat == wait_beat && s_wcnt < wait_n) begin
            bus.HREADY = 1'b0;
         end
      end
   end

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s_dp <= 1'b0; s_beat <= 0; s_wcnt <= 0; s_errph <= 1'b0;
      end else begin
         if (s_dp && !bus.HREADY) begin
            s_wcnt <= s_wcnt + 1;
            if (s_beat == err_beat) s_errph <= 1'b1;
         end else begin
            s_wcnt <= 0; s_errph <= 1'b0;
         end
         if (bus.HREADY) begin
            s_dp   <= bus.HTRANS[1];
            s_beat <= int'((bus.HADDR - cur_addr) >> 2);
         end
      end
   end

   // Monitor: pops the scoreboard as the DUT completes phases.
   xfer_t        xe;
   logic [31:0]  de;
   logic [70:0]  prev_snap;
   logic         prev_ok, prev_dp, prev_rdy;
   logic [1:0]   prev_resp;

   always @(negedge HCLK) begin
      if (HRESETn) begin
         if (bus.HTRANS[1] && bus.HREADY) begin
            if (exp_a.size() == 0) check("unexpected_xfer", {bus.HADDR, bus.HTRANS}, 0);
            else begin
               xe = exp_a.pop_front();
               check("addr_phase", {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HBURST, bus.HSIZE}, xe);
            end
         end
         if (s_dp && bus.HREADY && bus.HRESP == 2'b00) begin
            if (exp_wd.size() == 0) check("unexpected_data_phase", bus.HWDATA, 0);
            else begin
               de = exp_wd.pop_front();
               check("hwdata", bus.HWDATA, de);
            end
         end
         if (bus.rd_valid) begin
            if (exp_rd.size() == 0) check("unexpected_rd_valid", bus.rd_data, 0);
            else begin
               de = exp_rd.pop_front();
               check("rd_data", bus.rd_data, de);
            end
         end
         if (bus.done) done_cnt <= done_cnt + 1;
         if (bus.err) check("err_with_done", bus.done, 1);
         if (prev_ok && prev_dp && !prev_rdy && prev_resp == 2'b00)
            check("wait_hold", {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HBURST, bus.HWDATA}, prev_snap);
      end
      prev_snap <= {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HBURST, bus.HWDATA};
      prev_ok   <= HRESETn;
      prev_dp   <= s_dp;
      prev_rdy  <= bus.HREADY;
      prev_resp <= bus.HRESP;
   end

   task automatic push_exp(input vec_t c);
      bit bad;
      int nb, na, nok;
      bad = (c.addr[1:0] != 2'b00) || (c.burst && c.addr[9:0] > 10'h3F0);
      if (bad) return;
      nb  = c.burst ? 4 : 1;
      na  = (c.err_beat >= 0) ? c.err_beat + 1 : nb;
      nok = (c.err_beat >= 0) ? c.err_beat : nb;
      for (int i = 0; i < na; i++)
         exp_a.push_back({c.addr + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, c.wr,
                          c.burst ? 3'b011 : 3'b000, 3'b010});
      for (int i = 0; i < nok; i++) begin
         exp_wd.push_back(c.wr ? c.wdata[32 * i +: 32] : 32'h0);
         if (!c.wr) exp_rd.push_back(c.rbase + 32'(i));
      end
   endtask

   task automatic start_cmd(input vec_t c);
      int w;
      w = 0;
      while (!bus.cmd_ready && w < 50) begin @(negedge HCLK); w++; end
      check("cmd_ready_idle", bus.cmd_ready, 1);
      push_exp(c);
      wait_beat = c.wait_beat; wait_n = c.wait_n;
      err_beat = c.err_beat; err_code = c.err_code;
      cur_addr = c.addr; rd_base = c.rbase;
      bus.cmd_write = c.wr; bus.cmd_burst = c.burst;
      bus.cmd_addr = c.addr; bus.cmd_wdata = c.wdata;
      bus.cmd_valid = 1'b1;
      @(negedge HCLK);
   endtask

   task automatic run_cmd(input vec_t c, input int idx);
      int t0, w;
      start_cmd(c);
      t0 = cyc;
      n_cmds++;
      // a busy-time command must be ignored
      if (c.hold) bus.cmd_addr = 32'h0000_0006;
      w = 0;
      while (w < 60) begin
         if (w >= (c.hold ? 2 : 0)) bus.cmd_valid = 1'b0;
         if (bus.done) break;
         @(negedge HCLK);
         w++;
      end
      check($sformatf("done_seen[%0d]", idx), bus.done, 1);
      check($sformatf("latency[%0d]", idx), cyc - t0 + 1, c.exp_lat);
      check($sformatf("err[%0d]", idx), bus.err, c.exp_err);
      #1;
      check($sformatf("addr_left[%0d]", idx), exp_a.size(), 0);
      check($sformatf("wdata_left[%0d]", idx), exp_wd.size(), 0);
      check($sformatf("rdata_left[%0d]", idx), exp_rd.size(), 0);
      exp_a.delete(); exp_wd.delete(); exp_rd.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rc;
      int   w, dc0;
      HRESETn = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_burst = 1'b0;
      bus.cmd_addr = 32'h0; bus.cmd_wdata = 128'h0;

      //        wr    burst addr           wdata                                   rbase        wb  wn  eb  code  hold lat err
      tbl[0]  = '{1'b1, 1'b0, 32'h8000_0010, 128'hDEADBEEF,                        32'h0,       -1, 0, -1, 2'b01, 1'b0, 3, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 32'h8400_0000, 128'h0,                               32'h1,       -1, 0, -1, 2'b01, 1'b0, 6, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 32'h8000_0100, 128'h44444444_33333333_22222222_11111111, 32'h0,    1, 2, -1, 2'b01, 1'b0, 8, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 32'h8400_0040, 128'h0,                               32'hA0,      -1, 0,  2, 2'b01, 1'b0, 6, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 32'h8000_0002, 128'h0,                               32'h0,       -1, 0, -1, 2'b01, 1'b0, 1, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 32'h8000_03F4, 128'h5,                               32'h0,       -1, 0, -1, 2'b01, 1'b0, 1, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 32'h8000_03F0, 128'h0,                               32'h100,     -1, 0, -1, 2'b01, 1'b0, 6, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 32'h8000_0020, 128'h0,                               32'h7,       -1, 0,  0, 2'b10, 1'b0, 4, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 32'h8000_0200, 128'hDDDD0000_CCCC0000_BBBB0000_AAAA0000, 32'h0,   -1, 0,  3, 2'b11, 1'b0, 7, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 32'h8000_0300, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D, 32'h0, -1, 0, -1, 2'b01, 1'b1, 3, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 32'h8100_0000, 128'h0,                               32'h55,       0, 1, -1, 2'b01, 1'b0, 7, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 32'h8100_0080, 128'h0,                               32'h99,       0, 3, -1, 2'b01, 1'b0, 6, 1'b0};

      repeat (3) @(negedge HCLK);
      check("reset_values", out_vec(), RESET_VEC);
      HRESETn = 1'b1;
      @(negedge HCLK);
      check("idle_after_reset", out_vec(), RESET_VEC);

      // back-to-back: each command issued in the cycle the previous done is high
      for (int i = 0; i < 12; i++) run_cmd(tbl[i], i);

      // reset in the middle of an INCR4 read abandons it silently
      rc = '{1'b0, 1'b1, 32'h8200_0000, 128'h0, 32'h30, -1, 0, -1, 2'b01, 1'b0, 6, 1'b0};
      @(negedge HCLK);
      start_cmd(rc);
      bus.cmd_valid = 1'b0;
      w = 0;
      while (!(s_dp && s_beat == 2) && w < 20) begin @(negedge HCLK); w++; end
      check("reached_beat2", s_beat, 2);
      dc0 = done_cnt;
      HRESETn = 1'b0;
      #1;
      check("reset_midburst", out_vec(), RESET_VEC);
      exp_a.delete(); exp_wd.delete(); exp_rd.delete();
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (2) @(negedge HCLK);
      check("no_done_on_abort", done_cnt, dc0);
      check("idle_after_abort", out_vec(), RESET_VEC);
      rc = '{1'b1, 1'b0, 32'h8000_0040, 128'h1234_5678, 32'h0, -1, 0, -1, 2'b01, 1'b0, 3, 1'b0};
      run_cmd(rc, 12);

      repeat (2) @(negedge HCLK);
      check("done_count", done_cnt, n_cmds);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
